// File: rtl/uart_rx.sv
// UART receive stage: oversamples RX_IN, majority-votes three samples per bit,
// deserialises an LSB-first frame (start, data, optional parity, stop) and
// reports the word with a one-cycle valid pulse or one-cycle error pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  Busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Only 8, 16 and 32 are supported ratios; anything else runs at 8.
  function automatic logic [5:0] f_decode_prescale(input logic [5:0] p);
    logic [5:0] r;
    case (p)
      6'd16:   r = 6'd16;
      6'd32:   r = 6'd32;
      default: r = 6'd8;
    endcase
    return r;
  endfunction

  // Expected parity bit: even parity when typ=0, odd parity when typ=1.
  function automatic logic f_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
    return (^d) ^ typ;
  endfunction

  // 2-of-3 majority vote of the three bit samples.
  function automatic logic f_majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t                r_state;
  logic [5:0]            r_edge_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [5:0]            r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_fail;
  logic                  r_s0;
  logic                  r_s1;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic                  r_busy;

  logic [5:0] w_half;
  logic       w_samp0;
  logic       w_samp1;
  logic       w_decide;
  logic       w_last;
  logic       w_bit;

  // Sample/decision strobes within the current bit period and the voted bit.
  always_comb begin
    w_half   = r_prescale >> 1;
    w_samp0  = 1'b0;
    w_samp1  = 1'b0;
    w_decide = 1'b0;
    w_last   = 1'b0;
    if (r_state != IDLE) begin
      w_samp0  = (r_edge_cnt == (w_half - 6'd1));
      w_samp1  = (r_edge_cnt == w_half);
      w_decide = (r_edge_cnt == (w_half + 6'd1));
      w_last   = (r_edge_cnt == (r_prescale - 6'd1));
    end else begin
      w_samp0  = 1'b0;
    end
    w_bit = f_majority(r_s0, r_s1, RX_IN);
  end

  // Receive FSM, counters, shift register and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_edge_cnt   <= 6'd0;
      r_bit_cnt    <= {BW{1'b0}};
      r_prescale   <= 6'd8;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_par_fail   <= 1'b0;
      r_s0         <= 1'b0;
      r_s1         <= 1'b0;
      r_shift      <= {DATA_WIDTH{1'b0}};
      r_p_data     <= {DATA_WIDTH{1'b0}};
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;

      if (w_samp0) begin
        r_s0 <= RX_IN;
      end
      if (w_samp1) begin
        r_s1 <= RX_IN;
      end

      case (r_state)
        IDLE: begin
          r_edge_cnt <= 6'd0;
          r_bit_cnt  <= {BW{1'b0}};
          if (!RX_IN) begin
            // This cycle is edge 0 of the start bit; frame settings freeze here.
            r_state    <= START;
            r_edge_cnt <= 6'd1;
            r_busy     <= 1'b1;
            r_prescale <= f_decode_prescale(PRESCALE);
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_par_fail <= 1'b0;
          end
        end

        START: begin
          if (w_decide && w_bit) begin
            // Start bit voted high: a glitch, drop back silently.
            r_state    <= IDLE;
            r_edge_cnt <= 6'd0;
            r_busy     <= 1'b0;
          end else if (w_last) begin
            r_state    <= DATA;
            r_edge_cnt <= 6'd0;
            r_bit_cnt  <= {BW{1'b0}};
          end else begin
            r_edge_cnt <= r_edge_cnt + 6'd1;
          end
        end

        DATA: begin
          if (w_decide) begin
            r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
          end
          if (w_last) begin
            r_edge_cnt <= 6'd0;
            if (r_bit_cnt == BW'(DATA_WIDTH - 1)) begin
              r_state <= r_par_en ? PARITY : STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + {{(BW-1){1'b0}}, 1'b1};
            end
          end else begin
            r_edge_cnt <= r_edge_cnt + 6'd1;
          end
        end

        PARITY: begin
          if (w_decide) begin
            r_par_fail <= (w_bit != f_parity(r_shift, r_par_typ));
          end
          if (w_last) begin
            r_state    <= STOP;
            r_edge_cnt <= 6'd0;
          end else begin
            r_edge_cnt <= r_edge_cnt + 6'd1;
          end
        end

        STOP: begin
          if (w_decide) begin
            // Report now rather than waiting out the second half of the stop bit.
            r_stp_err  <= ~w_bit;
            r_par_err  <= r_par_fail;
            if (w_bit && !r_par_fail) begin
              r_p_data     <= r_shift;
              r_data_valid <= 1'b1;
            end
            r_state    <= IDLE;
            r_edge_cnt <= 6'd0;
            r_busy     <= 1'b0;
          end else begin
            r_edge_cnt <= r_edge_cnt + 6'd1;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_edge_cnt <= 6'd0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign P_DATA     = r_p_data;
  assign DATA_VALID = r_data_valid;
  assign PAR_ERR    = r_par_err;
  assign STP_ERR    = r_stp_err;
  assign Busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit by bit, the expected
// outcome of each frame is queued, and every output pulse is checked against it.
module tb_uart_rx;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       Busy;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR),
    .Busy       (Busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       serr;
    logic       dv;
  } exp_t;

  exp_t       q[$];
  logic [7:0] model_pdata = 8'h00;
  int         n_checks    = 0;
  int         n_errors    = 0;
  int         cyc         = 0;
  int         pulse_cnt   = 0;
  int         last_pulse  = -1;
  int         busy_rise   = -1;
  int         busy_fall   = -1;
  logic       prev_busy   = 1'b0;

  // 100 MHz clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycle index: during the cycle after posedge n, cyc == n.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Output monitor: tracks Busy edges and checks each pulse against the queue.
  always @(negedge CLK) begin
    exp_t e;
    if (Busy && !prev_busy) busy_rise = cyc;
    if (!Busy && prev_busy) busy_fall = cyc;
    prev_busy = Busy;
    if (DATA_VALID || PAR_ERR || STP_ERR) begin
      pulse_cnt++;
      last_pulse = cyc;
      if (q.size() == 0) begin
        check_val("spurious", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
      end else begin
        e = q.pop_front();
        check_val("dv",    {31'd0, DATA_VALID}, {31'd0, e.dv});
        check_val("perr",  {31'd0, PAR_ERR},    {31'd0, e.perr});
        check_val("serr",  {31'd0, STP_ERR},    {31'd0, e.serr});
        check_val("pdata", {24'd0, P_DATA},     {24'd0, e.data});
      end
    end
  end

  task automatic send_frame(input logic [7:0] data, input int p, input logic pen,
                            input logic ptyp, input logic bad_par, input logic bad_stop,
                            input logic glitch, input logic mid_change, output int t0);
    logic [10:0] bits;
    int          nb;
    exp_t        e;
    bits    = 11'd0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    nb = 9;
    if (pen) begin
      bits[nb] = (^data) ^ ptyp ^ bad_par;
      nb++;
    end
    bits[nb] = ~bad_stop;
    nb++;
    e.serr = bad_stop;
    e.perr = pen & bad_par;
    e.dv   = ~(e.serr | e.perr);
    if (e.dv) model_pdata = data;
    e.data = model_pdata;
    q.push_back(e);
    PRESCALE = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    t0 = cyc;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < p; k++) begin
        RX_IN = bits[b];
        if (glitch && b >= 1 && b <= 8 && k == p/2) RX_IN = ~bits[b];
        if (mid_change && b == 4 && k == 0) begin
          PRESCALE = (p == 32) ? 6'd16 : 6'd32;
          PAR_TYP  = ~ptyp;
        end
        tick();
      end
    end
    RX_IN = 1'b1;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) tick();
    check_val("drain", q.size(), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_pdata"}, {24'd0, P_DATA},     32'd0);
    check_val({tag, "_dv"},    {31'd0, DATA_VALID}, 32'd0);
    check_val({tag, "_perr"},  {31'd0, PAR_ERR},    32'd0);
    check_val({tag, "_serr"},  {31'd0, STP_ERR},    32'd0);
    check_val({tag, "_busy"},  {31'd0, Busy},       32'd0);
  endtask

  initial begin
    int t0;
    int pc;
    RST      = 1'b0;
    RX_IN    = 1'b1;
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    repeat (3) tick();
    @(negedge CLK);
    check_outputs_zero("rst");
    RST = 1'b1;
    tick();
    idle(4);

    // Basic frame with exact latency and Busy window.
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t0);
    idle(16);
    wait_drain();
    check_val("t1_lat",  last_pulse - t0, 32'd78);
    check_val("t1_rise", busy_rise - t0,  32'd1);
    check_val("t1_fall", busy_fall - t0,  32'd78);

    // Even parity, good then bad parity bit.
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t0);
    idle(8);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, t0);
    idle(8);
    wait_drain();

    // Stop bit low, then parity and stop both corrupted.
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, t0);
    idle(24);
    send_frame(8'h5A, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, t0);
    idle(24);
    wait_drain();

    // Two-cycle low glitch on idle line: detected, then rejected silently.
    pc = pulse_cnt;
    RX_IN = 1'b0;
    tick();
    tick();
    RX_IN = 1'b1;
    @(negedge CLK);
    check_val("glitch_busy_hi", {31'd0, Busy}, 32'd1);
    tick();
    idle(16);
    @(negedge CLK);
    check_val("glitch_busy_lo", {31'd0, Busy}, 32'd0);
    check_val("glitch_pulses",  pulse_cnt,     pc);
    tick();

    // Single inverted middle sample on every data bit.
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    idle(4);
    send_frame(8'h69, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    idle(8);
    wait_drain();

    // Back-to-back frames, then settings changed mid-frame.
    send_frame(8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, t0);
    send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, t0);
    idle(8);
    wait_drain();
    send_frame(8'h6B, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    idle(8);
    wait_drain();

    // Reset during data bit 4, then a clean frame.
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (8) tick();
    for (int b = 0; b < 4; b++) begin
      RX_IN = b[0];
      repeat (8) tick();
    end
    RX_IN = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    @(negedge CLK);
    check_outputs_zero("midrst");
    RST = 1'b1;
    model_pdata = 8'h00;
    tick();
    idle(8);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t0);
    idle(8);
    wait_drain();
    @(negedge CLK);
    check_val("final_pdata", {24'd0, P_DATA}, 32'h0000_00C3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
